xbar_write_forward_arbiter: RTL

Per-slave write-path scheduler for the crossbar: one instance sits in front of each slave port. Each cycle it grants one master's write-address request into the slave's AW FIFO with round-robin fairness. It records the grant order in an internal order FIFO and steers write-data beats so that W bursts reach the slave strictly in AW grant order, one whole burst (through WLAST) at a time.

---
 rtl/xbar_write_forward_arbiter_if.sv | 55 +++++
 rtl/xbar_write_forward_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/xbar_write_forward_arbiter_if.sv
// Write-path scheduling signals between one crossbar slave port and its arbiter.
// The arbiter uses the slave modport; the crossbar fabric (or a bench) uses master.
interface xbar_write_forward_arbiter_if #(
    parameter int masters       = 2,
    parameter int slaves        = 2,
    parameter int pending_depth = 8
);
    localparam int MW = (masters > 1) ? $clog2(masters) : 1;
    localparam int SW = (slaves > 1) ? $clog2(slaves) : 1;
    localparam int PW = (pending_depth > 1) ? $clog2(pending_depth) : 1;

    logic [masters-1:0]         master_write_addr_fifo_empty;
    logic [masters-1:0][SW-1:0] write_addr_forward_dest_slave;
    logic [masters-1:0]         master_write_data_fifo_empty;
    logic [masters-1:0][SW-1:0] write_data_forward_dest_slave;
    logic [masters-1:0]         master_WLAST;
    logic                       slave_write_addr_fifo_full;
    logic                       slave_write_data_fifo_full;

    logic                       aw_push;
    logic [MW-1:0]              aw_grant_master;
    logic                       w_push;
    logic [MW-1:0]              w_grant_master;
    logic [PW:0]                outstanding;

    modport slave (
        input  master_write_addr_fifo_empty,
        input  write_addr_forward_dest_slave,
        input  master_write_data_fifo_empty,
        input  write_data_forward_dest_slave,
        input  master_WLAST,
        input  slave_write_addr_fifo_full,
        input  slave_write_data_fifo_full,
        output aw_push,
        output aw_grant_master,
        output w_push,
        output w_grant_master,
        output outstanding
    );

    modport master (
        output master_write_addr_fifo_empty,
        output write_addr_forward_dest_slave,
        output master_write_data_fifo_empty,
        output write_data_forward_dest_slave,
        output master_WLAST,
        output slave_write_addr_fifo_full,
        output slave_write_data_fifo_full,
        input  aw_push,
        input  aw_grant_master,
        input  w_push,
        input  w_grant_master,
        input  outstanding
    );
endinterface

// File: rtl/xbar_write_forward_arbiter.sv
// Per-slave write scheduler: round-robin AW grant into the slave, with W bursts
// forwarded strictly in AW grant order, one whole burst (through WLAST) at a time.
module xbar_write_forward_arbiter #(
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0,
    parameter int pending_depth     = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    xbar_write_forward_arbiter_if.slave bus
);
    localparam int MW = (masters > 1) ? $clog2(masters) : 1;
    localparam int SW = (slaves > 1) ? $clog2(slaves) : 1;
    localparam int PW = (pending_depth > 1) ? $clog2(pending_depth) : 1;

    localparam logic [SW-1:0] MY_SLAVE  = SW'(i_am_slave_number);
    localparam logic [MW-1:0] LAST_MST  = MW'(masters - 1);
    localparam logic [MW:0]   MST_COUNT = (MW+1)'(masters);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(pending_depth);

    logic [MW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   outstanding_q, outstanding_d;
    logic [MW-1:0] order_mem_q [pending_depth];

    logic [masters-1:0] req;
    logic [MW-1:0]      winner;
    logic               any_req;
    logic [MW:0]        cand;
    logic [MW-1:0]      head;
    logic               order_full;
    logic               order_empty;
    logic               aw_push_c;
    logic               w_push_c;
    logic               deq;

    // A master requests this slave only when its AW front entry decodes to us.
    generate
        for (genvar gi = 0; gi < masters; gi++) begin : g_req
            assign req[gi] = ~bus.master_write_addr_fifo_empty[gi]
                           & (bus.write_addr_forward_dest_slave[gi] == MY_SLAVE);
        end
    endgenerate

    // Search starts at rr_ptr and wraps; the first requester found wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 0; k < masters; k++) begin
            cand = {1'b0, rr_ptr_q} + (MW+1)'(k);
            if (cand >= MST_COUNT) begin
                cand = cand - MST_COUNT;
            end
            if (!any_req && req[cand[MW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[MW-1:0];
            end
        end
    end

    assign order_full  = (outstanding_q == FULL_CNT);
    assign order_empty = (outstanding_q == '0);
    assign head        = order_mem_q[rd_ptr_q];

    // Pushes are held off while reset is asserted so nothing leaks into the slave FIFOs.
    assign aw_push_c = ARESETn & any_req & ~bus.slave_write_addr_fifo_full & ~order_full;

    assign w_push_c = ARESETn & ~order_empty
                    & ~bus.master_write_data_fifo_empty[head]
                    & (bus.write_data_forward_dest_slave[head] == MY_SLAVE)
                    & ~bus.slave_write_data_fifo_full;

    assign deq = w_push_c & bus.master_WLAST[head];

    assign bus.aw_push         = aw_push_c;
    assign bus.aw_grant_master = aw_push_c ? winner : '0;
    assign bus.w_push          = w_push_c;
    assign bus.w_grant_master  = w_push_c ? head : '0;
    assign bus.outstanding     = outstanding_q;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        if (aw_push_c) begin
            rr_ptr_d = (winner == LAST_MST) ? '0 : winner + MW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({aw_push_c, deq})
            2'b10:   outstanding_d = outstanding_q + (PW+1)'(1);
            2'b01:   outstanding_d = outstanding_q - (PW+1)'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Storage needs no reset: entries are only read below the occupancy count.
    always_ff @(posedge ACLK) begin
        if (aw_push_c) begin
            order_mem_q[wr_ptr_q] <= winner;
        end
    end

    a_no_push_when_full : assert property (@(posedge ACLK) disable iff (!ARESETn)
        order_full |-> !aw_push_c);
    a_no_w_when_empty : assert property (@(posedge ACLK) disable iff (!ARESETn)
        order_empty |-> !w_push_c);
    a_count_bounded : assert property (@(posedge ACLK) disable iff (!ARESETn)
        outstanding_q <= FULL_CNT);

endmodule
